// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Digit-serial WIDTH-bit adder/subtractor. Operands are captured on an
// accepted start and consumed DIGIT bits per clock, least significant digit
// first, with the inter-digit carry kept in a register. The result, carry out
// and signed overflow are written on the last-digit edge together with a
// one-cycle done pulse. They hold until the next operation completes.
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits processed per clock; must divide WIDTH exactly
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   request, sampled only while idle
//   sub    in   0: a+b+cin, 1: a-b (cin ignored)
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry in, captured on accepted start
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when sum/cout/ovf have been updated
//   sum    out  WIDTH-bit registered result
//   cout   out  carry out of the MSB
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic [DIGIT:0]   w_dsum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  // One digit of the addition; bit DIGIT is the carry out of this digit.
  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, r_carry};

  // Carry into the top bit of the digit, recovered from the sum bit and the
  // two operand bits. On the last digit this is the carry into bit WIDTH-1.
  assign w_cmsb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  // New digit enters from the MSB side, so after NDIG digits the first digit
  // has reached the LSB position.
  assign w_acc_next = (r_acc >> DIGIT)
                    | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  assign w_last = (r_cnt == LAST);
  assign busy   = (r_state == S_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and force the initial carry.
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub | cin;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
      end else begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dsum[DIGIT];
        r_acc   <= w_acc_next;
        r_cnt   <= r_cnt + 1'b1;
        if (w_last) begin
          r_state <= S_IDLE;
          sum     <= w_acc_next;
          cout    <= w_dsum[DIGIT];
          ovf     <= w_cmsb ^ w_dsum[DIGIT];
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Four instances of serial_adder share clock and reset:
//   k=0 : WIDTH=8 DIGIT=1  (directed cases, handshake, reset abort, random)
//   k=1 : WIDTH=3 DIGIT=1  (exhaustive)
//   k=2 : WIDTH=8 DIGIT=4  (random)
//   k=3 : WIDTH=8 DIGIT=8  (random)
// Issued operations push their expected result and completion cycle into a
// scoreboard queue; a monitor on the falling edge pops and compares whenever
// an instance pulses done, and otherwise checks that the outputs hold.
// ---------------------------------------------------------------------------
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start_s [4];
  logic       sub_s   [4];
  logic       cin_s   [4];
  logic [7:0] a_s     [4];
  logic [7:0] b_s     [4];
  wire        busy_s  [4];
  wire        done_s  [4];
  wire        cout_s  [4];
  wire        ovf_s   [4];
  wire  [7:0] sum_s   [4];

  for (genvar k = 0; k < 4; k++) begin : g_dut
    localparam int W = (k == 1) ? 3 : 8;
    localparam int D = (k == 2) ? 4 : ((k == 3) ? 8 : 1);
    wire [W-1:0] w_sum;
    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_s[k]),
      .sub   (sub_s[k]),
      .a     (a_s[k][W-1:0]),
      .b     (b_s[k][W-1:0]),
      .cin   (cin_s[k]),
      .busy  (busy_s[k]),
      .done  (done_s[k]),
      .sum   (w_sum),
      .cout  (cout_s[k]),
      .ovf   (ovf_s[k])
    );
    assign sum_s[k] = 8'(w_sum);
  end

  function automatic int cfg_w(int k);
    return (k == 1) ? 3 : 8;
  endfunction

  function automatic int cfg_lat(int k);
    return (k == 2) ? 2 : ((k == 3) ? 1 : cfg_w(k));
  endfunction

  typedef struct {
    int         k;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t       sbq[$];
  logic [9:0] held [4];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(int k, int a, int b, int cin, int sub);
    exp_t e;
    int w, m, full, sa, sb, ts;
    w  = cfg_w(k);
    m  = (1 << w) - 1;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    if (sub != 0) begin
      full   = a - b;
      e.cout = (a >= b);
      ts     = sa - sb;
    end else begin
      full   = a + b + cin;
      e.cout = (full > m);
      ts     = sa + sb + cin;
    end
    e.sum = 8'(full & m);
    e.ovf = (ts > (1 << (w - 1)) - 1) || (ts < -(1 << (w - 1)));
    e.k   = k;
    e.cyc = 0;
    return e;
  endfunction

  // Monitor
  int   mi;
  exp_t me;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        chk($sformatf("reset_outputs[%0d]", k),
            {busy_s[k], done_s[k], sum_s[k], cout_s[k], ovf_s[k]}, 0);
        held[k] = '0;
      end else if (done_s[k]) begin
        mi = -1;
        for (int i = 0; i < sbq.size(); i++)
          if (mi < 0 && sbq[i].k == k) mi = i;
        if (mi < 0) begin
          chk($sformatf("unexpected_done[%0d]", k), 32'(done_s[k]), 0);
        end else begin
          me = sbq[mi];
          sbq.delete(mi);
          chk($sformatf("sum[%0d]", k),  sum_s[k],  me.sum);
          chk($sformatf("cout[%0d]", k), cout_s[k], me.cout);
          chk($sformatf("ovf[%0d]", k),  ovf_s[k],  me.ovf);
          chk($sformatf("done_cycle[%0d]", k), cyc, me.cyc);
          held[k] = {me.sum, me.cout, me.ovf};
        end
      end else begin
        chk($sformatf("hold[%0d]", k), {sum_s[k], cout_s[k], ovf_s[k]}, held[k]);
      end
    end
  end

  // Called just after a rising edge; the start is seen at the next edge.
  task automatic issue(int k, int a, int b, int cin, int sub, output int tgt);
    exp_t e;
    e = model(k, a, b, cin, sub);
    start_s[k] = 1'b1;
    a_s[k]     = 8'(a);
    b_s[k]     = 8'(b);
    cin_s[k]   = cin[0];
    sub_s[k]   = sub[0];
    e.cyc      = cyc + 1 + cfg_lat(k);
    tgt        = e.cyc;
    sbq.push_back(e);
    @(posedge clk); #1;
    start_s[k] = 1'b0;
    // Operand changes during RUN must not disturb the result.
    a_s[k]     = 8'($urandom);
    b_s[k]     = 8'($urandom);
    cin_s[k]   = 1'($urandom);
    sub_s[k]   = 1'($urandom);
    chk($sformatf("busy_after_start[%0d]", k), 32'(busy_s[k]), 1);
  endtask

  task automatic wait_cyc(int tgt);
    while (cyc < tgt) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(int k, int a, int b, int cin, int sub);
    int tgt;
    issue(k, a, b, cin, sub, tgt);
    wait_cyc(tgt);
    chk($sformatf("busy_in_done_cycle[%0d]", k), 32'(busy_s[k]), 0);
  endtask

  task automatic run_random(int k, int n);
    int m;
    m = (1 << cfg_w(k)) - 1;
    for (int i = 0; i < n; i++)
      run_op(k, int'($urandom_range(0, m)), int'($urandom_range(0, m)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int tgt;
    for (int k = 0; k < 4; k++) begin
      start_s[k] = 1'b0; sub_s[k] = 1'b0; cin_s[k] = 1'b0;
      a_s[k] = '0; b_s[k] = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic cases
    run_op(0, 'h5A, 'h33, 0, 0);
    run_op(0, 'hFF, 'h01, 1, 0);
    run_op(0, 'h10, 'h20, 0, 1);
    run_op(0, 'h80, 'h01, 1, 1);

    // start pulses during RUN cycles 2 and 4 are ignored
    issue(0, 'hC3, 'h5C, 0, 0, tgt);
    @(posedge clk); #1;
    start_s[0] = 1'b1; a_s[0] = 8'h11; b_s[0] = 8'h22;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    @(posedge clk); #1;
    start_s[0] = 1'b1; a_s[0] = 8'h77; b_s[0] = 8'h66; sub_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    wait_cyc(tgt);
    repeat (12) @(posedge clk);
    #1;

    // start held in the done cycle is accepted immediately
    issue(0, 'h7F, 'h01, 0, 0, tgt);
    wait_cyc(tgt);
    issue(0, 'h00, 'h01, 0, 1, tgt);
    wait_cyc(tgt);
    chk("busy_after_back_to_back", 32'(busy_s[0]), 0);

    // Reset in RUN cycle 3 aborts the operation with no done pulse
    run_op(0, 'h5A, 'h33, 0, 0);
    issue(0, 'h12, 'h34, 1, 0, tgt);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sbq.delete();
    #1;
    chk("abort_busy", 32'(busy_s[0]), 0);
    chk("abort_outputs", {done_s[0], sum_s[0], cout_s[0], ovf_s[0]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    run_op(0, 'hA5, 'h5B, 1, 0);

    // Randomised runs and sweeps
    run_random(0, 60);
    for (int n = 0; n < 256; n++)
      run_op(1, n & 7, (n >> 3) & 7, (n >> 6) & 1, (n >> 7) & 1);
    run_random(2, 60);
    run_random(3, 60);

    repeat (5) @(posedge clk);
    #1;
    chk("pending_results", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
